// File: rtl/mat2x2_mac_engine.sv
// Signed fixed-point 2x2 matrix multiply-accumulate, C = A*B (+ C_prev),
// time-sharing one multiplier across 8 MAC cycles with saturate-or-wrap post-processing.
module mat2x2_mac_engine #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int SATURATE = 1
) (
  input  logic                    input_Clk,
  input  logic                    input_Reset,
  input  logic                    input_Stable,
  input  logic                    input_Accumulate,
  input  logic signed [WIDTH-1:0] input_A11,
  input  logic signed [WIDTH-1:0] input_A12,
  input  logic signed [WIDTH-1:0] input_A21,
  input  logic signed [WIDTH-1:0] input_A22,
  input  logic signed [WIDTH-1:0] input_B11,
  input  logic signed [WIDTH-1:0] input_B12,
  input  logic signed [WIDTH-1:0] input_B21,
  input  logic signed [WIDTH-1:0] input_B22,
  input  logic                    input_C_Ack,
  output logic                    output_AB_Ack,
  output logic                    output_Stable,
  output logic signed [WIDTH-1:0] output_C11,
  output logic signed [WIDTH-1:0] output_C12,
  output logic signed [WIDTH-1:0] output_C21,
  output logic signed [WIDTH-1:0] output_C22,
  output logic                    output_Overflow,
  output logic                    output_Busy
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + 2;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              cnt;
  logic                    acc_mode;
  logic signed [AW-1:0]    acc;
  logic signed [WIDTH-1:0] a_reg [2][2];
  logic signed [WIDTH-1:0] b_reg [2][2];
  logic signed [WIDTH-1:0] stage [4];
  logic [3:0]              stage_ovf;
  logic signed [WIDTH-1:0] c_out [4];

  logic [1:0]              elem;
  logic                    k;
  logic signed [WIDTH-1:0] op_a, op_b;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    sum;
  logic [WIDTH:0]          pp;
  logic                    capture;

  // Previous result element, scaled into accumulator alignment.
  function automatic logic signed [AW-1:0] acc_seed(input logic signed [WIDTH-1:0] c);
    logic signed [AW-1:0] ext;
    ext = {{(AW-WIDTH){c[WIDTH-1]}}, c};
    return ext <<< FRAC;
  endfunction

  // Drop FRAC bits (floor), then clamp or wrap; MSB of the result flags out-of-range.
  function automatic logic [WIDTH:0] post_process(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] s, max_v, min_v;
    s     = v >>> FRAC;
    max_v = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    min_v = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    if (s > max_v)
      return {1'b1, (SATURATE != 0) ? max_v[WIDTH-1:0] : s[WIDTH-1:0]};
    else if (s < min_v)
      return {1'b1, (SATURATE != 0) ? min_v[WIDTH-1:0] : s[WIDTH-1:0]};
    else
      return {1'b0, s[WIDTH-1:0]};
  endfunction

  assign elem    = cnt[2:1];
  assign k       = cnt[0];
  assign op_a    = a_reg[elem[1]][k];
  assign op_b    = b_reg[k][elem[0]];
  assign prod    = op_a * op_b;
  assign sum     = acc + {{(AW-PW){prod[PW-1]}}, prod};
  assign pp      = post_process(sum);
  assign capture = (state == IDLE) && input_Stable;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (input_Stable) state_nxt = MAC;
      MAC:     if (cnt == 3'd7) state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    if (input_C_Ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) begin
      state           <= IDLE;
      cnt             <= 3'd0;
      acc_mode        <= 1'b0;
      acc             <= '0;
      output_AB_Ack   <= 1'b0;
      output_Stable   <= 1'b0;
      output_Overflow <= 1'b0;
      for (int i = 0; i < 4; i++) c_out[i] <= '0;
    end else begin
      state         <= state_nxt;
      output_AB_Ack <= capture;
      if (capture) begin
        cnt      <= 3'd0;
        acc_mode <= input_Accumulate;
        acc      <= input_Accumulate ? acc_seed(c_out[0]) : '0;
      end
      if (state == MAC) begin
        cnt <= cnt + 3'd1;
        // Second product closes the element; reseed for the next one.
        if (k) acc <= acc_mode ? acc_seed(c_out[elem + 2'd1]) : '0;
        else   acc <= sum;
      end
      if (state == WRITE) begin
        for (int i = 0; i < 4; i++) c_out[i] <= stage[i];
        output_Overflow <= |stage_ovf;
        output_Stable   <= 1'b1;
      end
      if (state == DONE && input_C_Ack) output_Stable <= 1'b0;
    end
  end

  // Operand and staging registers carry data only and need no reset.
  always_ff @(posedge input_Clk) begin
    if (capture) begin
      a_reg[0][0] <= input_A11;
      a_reg[0][1] <= input_A12;
      a_reg[1][0] <= input_A21;
      a_reg[1][1] <= input_A22;
      b_reg[0][0] <= input_B11;
      b_reg[0][1] <= input_B12;
      b_reg[1][0] <= input_B21;
      b_reg[1][1] <= input_B22;
    end
    if (state == MAC && k) begin
      stage[elem]     <= pp[WIDTH-1:0];
      stage_ovf[elem] <= pp[WIDTH];
    end
  end

  assign output_C11  = c_out[0];
  assign output_C12  = c_out[1];
  assign output_C21  = c_out[2];
  assign output_C22  = c_out[3];
  assign output_Busy = (state == MAC) || (state == WRITE);

endmodule
